// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter in front of the register-file write port, with a one-entry buffer per requester.
// Define REGFILE_WRITE_ARBITER_RR_EN to resolve contested grants round-robin instead of REQ0-first.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_DATA,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_DATA,
  output logic              WE_OUT,
  output logic [ADDR_W-1:0] WADDR_OUT,
  output logic [DATA_W-1:0] WDATA_OUT,
  output logic              BUSY
);

  logic              hold0, hold1;
  logic              old0, old1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              grant0, grant1;
  logic              new0, new1;
  logic              hold0_nxt, hold1_nxt;
  logic              contested;

  assign contested = hold0 & hold1 & (addr0 != addr1);

`ifdef REGFILE_WRITE_ARBITER_RR_EN
  logic rr_ptr;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rr_ptr <= 1'b0;
    end else if (contested) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (hold0 && !hold1) begin
      grant0 = 1'b1;
    end else if (!hold0 && hold1) begin
      grant1 = 1'b1;
    end else if (hold0 && hold1) begin
      if (!contested) begin
        // same register: the older write must land first
        if (old1 && !old0) grant1 = 1'b1;
        else               grant0 = 1'b1;
      end else begin
`ifdef REGFILE_WRITE_ARBITER_RR_EN
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
`else
        grant0 = 1'b1;
`endif
      end
    end
  end

  assign REQ0_READY = RESET & (~hold0 | grant0);
  assign REQ1_READY = RESET & (~hold1 | grant1);

  // x0 is hardwired zero, so writes to it complete the handshake and vanish
  assign new0 = REQ0_VALID & REQ0_READY & (REQ0_ADDR != '0);
  assign new1 = REQ1_VALID & REQ1_READY & (REQ1_ADDR != '0);

  assign hold0_nxt = new0 | (hold0 & ~grant0);
  assign hold1_nxt = new1 | (hold1 & ~grant1);

  assign BUSY = RESET & (hold0 | hold1 | WE_OUT);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hold0     <= 1'b0;
      hold1     <= 1'b0;
      old0      <= 1'b0;
      old1      <= 1'b0;
      addr0     <= '0;
      addr1     <= '0;
      data0     <= '0;
      data1     <= '0;
      WE_OUT    <= 1'b0;
      WADDR_OUT <= '0;
      WDATA_OUT <= '0;
    end else begin
      hold0 <= hold0_nxt;
      hold1 <= hold1_nxt;
      if (new0) begin
        addr0 <= REQ0_ADDR;
        data0 <= REQ0_DATA;
      end
      if (new1) begin
        addr1 <= REQ1_ADDR;
        data1 <= REQ1_DATA;
      end
      // a fresh entry is younger than whatever is still held alongside it
      if (new0 && new1) begin
        old0 <= 1'b1;
        old1 <= 1'b0;
      end else if (new0) begin
        old0 <= ~hold1_nxt;
        old1 <= 1'b1;
      end else if (new1) begin
        old0 <= 1'b1;
        old1 <= ~hold0_nxt;
      end else begin
        old0 <= old0 | grant1;
        old1 <= old1 | grant0;
      end
      WE_OUT <= grant0 | grant1;
      if (grant0) begin
        WADDR_OUT <= addr0;
        WDATA_OUT <= data0;
      end else if (grant1) begin
        WADDR_OUT <= addr1;
        WDATA_OUT <= data1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares every WE_OUT pulse; a small reg_file model tracks final contents.
module tb_regfile_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              REQ0_VALID, REQ0_READY;
  logic [ADDR_W-1:0] REQ0_ADDR;
  logic [DATA_W-1:0] REQ0_DATA;
  logic              REQ1_VALID, REQ1_READY;
  logic [ADDR_W-1:0] REQ1_ADDR;
  logic [DATA_W-1:0] REQ1_DATA;
  logic              WE_OUT;
  logic [ADDR_W-1:0] WADDR_OUT;
  logic [DATA_W-1:0] WDATA_OUT;
  logic              BUSY;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [DATA_W-1:0] rf [32];
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA),
    .WE_OUT(WE_OUT), .WADDR_OUT(WADDR_OUT), .WDATA_OUT(WDATA_OUT), .BUSY(BUSY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // reg_file model
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge CLK) if (WE_OUT === 1'b1) rf[WADDR_OUT] <= WDATA_OUT;

  // monitor
  always @(negedge CLK) begin
    if (WE_OUT === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", WADDR_OUT, WDATA_OUT);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.addr !== WADDR_OUT || mon_e.data !== WDATA_OUT) begin
          errors++;
          $display("FAIL write_order: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                   WADDR_OUT, WDATA_OUT, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    // 1: reset with both requesters pushing
    RESET = 1'b0;
    REQ0_VALID = 1'b1; REQ0_ADDR = 5'd2; REQ0_DATA = 32'h1234;
    REQ1_VALID = 1'b1; REQ1_ADDR = 5'd6; REQ1_DATA = 32'h5678;
    cyc(2);
    chk("rst_ready0", REQ0_READY, 1'b0);
    chk("rst_ready1", REQ1_READY, 1'b0);
    chk("rst_we", WE_OUT, 1'b0);
    chk("rst_waddr", WADDR_OUT, 0);
    chk("rst_wdata", WDATA_OUT, 0);
    chk("rst_busy", BUSY, 1'b0);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    RESET = 1'b1;
    #1;
    chk("rel_ready0", REQ0_READY, 1'b1);
    chk("rel_ready1", REQ1_READY, 1'b1);

    // 2: single write latency
    cyc(1);
    REQ0_VALID = 1'b1; REQ0_ADDR = 5'd5; REQ0_DATA = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF);
    cyc(1);
    REQ0_VALID = 1'b0;
    chk("single_we_t0", WE_OUT, 1'b0);
    chk("single_busy_t0", BUSY, 1'b1);
    cyc(1);
    chk("single_we_t1", WE_OUT, 1'b1);
    chk("single_waddr_t1", WADDR_OUT, 5);
    chk("single_wdata_t1", WDATA_OUT, 32'hDEADBEEF);
    cyc(1);
    chk("single_we_t2", WE_OUT, 1'b0);
    chk("single_rf5", rf[5], 32'hDEADBEEF);
    chk("single_busy_t2", BUSY, 1'b0);

    // 4: same-address ordering behind a stalled REQ1 entry
    REQ0_VALID = 1'b1; REQ0_ADDR = 5'd1; REQ0_DATA = 32'h100;
    REQ1_VALID = 1'b1; REQ1_ADDR = 5'd7; REQ1_DATA = 32'hA;
    push(5'd1, 32'h100);
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    cyc(1);
    chk("same_ready1_stalled", REQ1_READY, 1'b0);
    chk("same_ready0_refill", REQ0_READY, 1'b1);
    REQ0_ADDR = 5'd7; REQ0_DATA = 32'hB;
    REQ1_VALID = 1'b0;
    cyc(1);
    REQ0_VALID = 1'b0;
    cyc(4);
    chk("same_rf7", rf[7], 32'hB);
    chk("same_rf1", rf[1], 32'h100);
    chk("same_busy", BUSY, 1'b0);

    // 3: contention on different registers (RR pointer is 1 here in the RR build)
    REQ0_VALID = 1'b1; REQ0_ADDR = 5'd3; REQ0_DATA = 32'h11;
    REQ1_VALID = 1'b1; REQ1_ADDR = 5'd4; REQ1_DATA = 32'h22;
`ifdef REGFILE_WRITE_ARBITER_RR_EN
    push(5'd4, 32'h22);
    push(5'd3, 32'h11);
`else
    push(5'd3, 32'h11);
    push(5'd4, 32'h22);
`endif
    cyc(1);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    cyc(1);
`ifdef REGFILE_WRITE_ARBITER_RR_EN
    chk("cont_first", WADDR_OUT, 4);
`else
    chk("cont_first", WADDR_OUT, 3);
`endif
    chk("cont_we1", WE_OUT, 1'b1);
    cyc(1);
`ifdef REGFILE_WRITE_ARBITER_RR_EN
    chk("cont_second", WADDR_OUT, 3);
`else
    chk("cont_second", WADDR_OUT, 4);
`endif
    chk("cont_we2", WE_OUT, 1'b1);
    cyc(2);
    chk("cont_rf3", rf[3], 32'h11);
    chk("cont_rf4", rf[4], 32'h22);

    // 5: write to x0 is dropped
    REQ1_VALID = 1'b1; REQ1_ADDR = 5'd0; REQ1_DATA = 32'hFFFF;
    #1;
    chk("x0_ready_before", REQ1_READY, 1'b1);
    cyc(1);
    REQ1_VALID = 1'b0;
    chk("x0_ready_after", REQ1_READY, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("x0_busy", BUSY, 1'b0);
      chk("x0_we", WE_OUT, 1'b0);
      cyc(1);
    end

    // 6: reset with both holds occupied
    REQ0_VALID = 1'b1; REQ0_ADDR = 5'd9;  REQ0_DATA = 32'h99;
    REQ1_VALID = 1'b1; REQ1_ADDR = 5'd10; REQ1_DATA = 32'hAA;
    cyc(1);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    chk("mid_busy_before", BUSY, 1'b1);
    RESET = 1'b0;
    cyc(1);
    chk("mid_we", WE_OUT, 1'b0);
    chk("mid_busy", BUSY, 1'b0);
    chk("mid_ready0", REQ0_READY, 1'b0);
    RESET = 1'b1;
    cyc(5);
    chk("mid_rf9", rf[9], 0);
    chk("mid_rf10", rf[10], 0);
    chk("mid_busy_after", BUSY, 1'b0);
    chk("mid_we_after", WE_OUT, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (IN, INADDRESS, WRITEENABLE) between two writeback requesters: REQ0 (ALU writeback) and REQ1 (load/memory writeback).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- The arbiter issues at most one registered write per cycle and preserves write order to the same register.
- Sits between the pipeline WB stage and reg_file.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-low reset
- REQ0_VALID  in  1  requester 0 has a write
- REQ0_READY  out  1  requester 0 write accepted this cycle if VALID
- REQ0_ADDR  in  ADDR_W  destination register, requester 0
- REQ0_DATA  in  DATA_W  write data, requester 0
- REQ1_VALID  in  1  requester 1 has a write
- REQ1_READY  out  1  requester 1 write accepted this cycle if VALID
- REQ1_ADDR  in  ADDR_W  destination register, requester 1
- REQ1_DATA  in  DATA_W  write data, requester 1
- WE_OUT  out  1  to reg_file WRITEENABLE, registered
- WADDR_OUT  out  ADDR_W  to reg_file INADDRESS, registered
- WDATA_OUT  out  DATA_W  to reg_file IN, registered
- BUSY  out  1  any buffer held or WE_OUT high; used by the hazard unit

Behaviour:
- Reset: at a posedge with RESET==0, the following are cleared: both holds, both age bits, WE_OUT=0, WADDR_OUT=0, WDATA_OUT=0, RR pointer=0.
- While RESET==0, REQ0_READY=REQ1_READY=0 and BUSY=0.
- Reset has priority over every other event. Reset mid-operation discards held writes and any pending WE.
- Hold n state: hold_n (valid flag), addr_n, data_n, old_n (age bit).
- Ready: REQn_READY = RESET & (~hold_n | grant_n). This gives full throughput: a buffer is refilled in the same cycle it issues.
- Accept: a write is accepted at the edge where REQn_VALID & REQn_READY.
- Accepted address 0: handshake completes but nothing is stored. hold_n stays clear and no write is ever issued (x0 is hardwired zero).
- Grant, combinational, from the holds only:
  - Exactly one hold set: that requester wins.
  - Both set, same addr: the older entry wins (old_n==1).
  - Both set, different addr: the policy decides. Fixed priority gives REQ0; see Optional Feature.
- Issue: at an edge with a grant, WE_OUT<=1 and WADDR_OUT/WDATA_OUT<=winner's addr/data. The winner's hold clears unless it is refilled at that same edge.
- No grant: WE_OUT<=0; WADDR_OUT/WDATA_OUT hold their value.
- Latency: accept at edge t0, WE_OUT high during the cycle after edge t1, reg_file writes at edge t2. Back-to-back single-requester throughput is 1 write per cycle.
- Age rules:
  - An entry accepted while the other hold is valid gets old=0; the other entry gets old=1.
  - Both accepted at the same edge: REQ0 gets old=1.
  - An entry that is sole occupant gets old=1.
  - When one entry issues, the remaining entry gets old=1.
- Maximum wait for a non-priority entry in fixed-priority mode is unbounded only if REQ0 refills every cycle. Round-robin bounds it to 1 cycle.
- BUSY = hold0 | hold1 | WE_OUT.

Optional Feature:
- Macro: REGFILE_WRITE_ARBITER_RR_EN.
- Defined: for both held with different addr, round-robin. The winner is the requester indicated by a 1-bit RR pointer, which toggles to the other requester after every contested grant. Uncontested grants leave the pointer unchanged.
- Not defined: fixed priority, REQ0 wins contested grants; the RR pointer is not implemented.
- The same-address oldest-first rule applies in both builds.

Test Plan:
1. Reset: drive RESET=0 for 2 edges with both VALID=1 -> READY0/1=0, WE_OUT=0, WADDR_OUT=0, WDATA_OUT=0, BUSY=0; release RESET -> READY0/1=1 next cycle.
2. Single write: REQ0 addr=5 data=0xDEADBEEF accepted at t0 -> WE_OUT=1, WADDR_OUT=5, WDATA_OUT=0xDEADBEEF in the cycle after t1 only; reg_file reads 0xDEADBEEF at reg 5 afterward.
3. Contention, different addr: both accept at the same edge, REQ0 addr=3 data=0x11, REQ1 addr=4 data=0x22 -> fixed-priority build issues 3 then 4 on consecutive cycles. RR build with pointer=1 issues 4 then 3.
4. Same-address ordering: REQ1 addr=7 data=0xA accepted at t0, REQ0 addr=7 data=0xB accepted at t1 while hold1 is still valid (forced by a stalled prior issue) -> issue order 0xA then 0xB; reg 7 finally holds 0xB.
5. x0 drop: REQ1 addr=0 data=0xFFFF accepted -> READY1 stays 1, WE_OUT never asserts for it, BUSY stays 0.
6. Reset mid-operation: both holds valid, RESET=0 at the next edge -> WE_OUT=0, holds cleared; after release no stale write appears.
